// File: rtl/seq_detector_param.sv
// Serial N-bit pattern detector with a run-time loadable pattern, selectable
// overlap and Mealy/Moore output timing, and a saturating hit counter.
module seq_detector_param #(
    parameter int             N           = 4,
    parameter logic [N-1:0]   DEFAULT_PAT = N'(4'b1011),
    parameter int             CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             in_valid,
    input  logic [N-1:0]     pattern,
    input  logic             pat_load,
    input  logic             overlap,
    input  logic             moore,
    input  logic             cnt_clr,
    output logic             z,
    output logic [CNT_W-1:0] hit_count
);

    localparam int FW = $clog2(N + 1);

    logic [N-1:0]     pat_reg,  pat_next;
    logic [N-1:0]     hist_reg, hist_next;
    logic [FW-1:0]    fill_reg, fill_next;
    logic             z_q_reg,  z_q_next;
    logic [CNT_W-1:0] cnt_reg,  cnt_next;

    logic [N-1:0] window;
    logic         hist_full;
    logic         match;

    // Newest bit enters at the LSB, so the window lines up with a pattern
    // whose first-received bit is the MSB.
    assign window    = {hist_reg[N-2:0], x};
    assign hist_full = (fill_reg >= FW'(N - 1));
    assign match     = in_valid & ~pat_load & hist_full & (window == pat_reg);

    always_comb begin
        pat_next  = pat_reg;
        hist_next = hist_reg;
        fill_next = fill_reg;
        z_q_next  = match;
        cnt_next  = cnt_reg;

        if (pat_load) begin
            pat_next  = pattern;
            hist_next = '0;
            fill_next = '0;
            z_q_next  = 1'b0;
        end else if (in_valid) begin
            hist_next = window;
            // Non-overlapping: forget the matched bits so the next hit
            // needs a completely fresh window.
            if (match && !overlap) begin
                fill_next = '0;
            end else if (fill_reg != FW'(N)) begin
                fill_next = fill_reg + 1'b1;
            end
        end

        if (cnt_clr) begin
            cnt_next = '0;
        end else if (match && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_reg  <= DEFAULT_PAT;
            hist_reg <= '0;
            fill_reg <= '0;
            z_q_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            pat_reg  <= pat_next;
            hist_reg <= hist_next;
            fill_reg <= fill_next;
            z_q_reg  <= z_q_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign z         = moore ? z_q_reg : match;
    assign hit_count = cnt_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: two instances share all inputs, one
// with an 8-bit hit counter and one with a 2-bit counter for saturation.
module tb_seq_detector_param;

    logic       clk;
    logic       reset;
    logic       x;
    logic       in_valid;
    logic [3:0] pattern;
    logic       pat_load;
    logic       overlap;
    logic       moore;
    logic       cnt_clr;
    logic       z_a, z_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int compared   = 0;
    int mismatched = 0;

    seq_detector_param #(.N(4), .DEFAULT_PAT(4'b1011), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .x(x), .in_valid(in_valid),
        .pattern(pattern), .pat_load(pat_load), .overlap(overlap),
        .moore(moore), .cnt_clr(cnt_clr), .z(z_a), .hit_count(cnt_a)
    );

    seq_detector_param #(.N(4), .DEFAULT_PAT(4'b1011), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .x(x), .in_valid(in_valid),
        .pattern(pattern), .pat_load(pat_load), .overlap(overlap),
        .moore(moore), .cnt_clr(cnt_clr), .z(z_b), .hit_count(cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input int observed, input int expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one cycle of inputs, check z mid-cycle, then cross the edge.
    task automatic step(input logic b, input logic v, input logic ld, input logic clr,
                        input logic [3:0] pat, input logic exp_z, input string tag);
        x        = b;
        in_valid = v;
        pat_load = ld;
        cnt_clr  = clr;
        pattern  = pat;
        @(negedge clk);
        check({tag, " z"}, int'(z_a), int'(exp_z));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pat_load = 1'b0;
        cnt_clr  = 1'b0;
    endtask

    task automatic bit_in(input logic b, input logic exp_z, input string tag);
        step(b, 1'b1, 1'b0, 1'b0, 4'b0000, exp_z, tag);
    endtask

    task automatic load(input logic [3:0] pat, input string tag);
        step(1'b0, 1'b0, 1'b1, 1'b0, pat, 1'b0, tag);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, " rst z"},   int'(z_a),   0);
        check({tag, " rst cnt"}, int'(cnt_a), 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        x        = 1'b0;
        in_valid = 1'b0;
        pattern  = 4'b0000;
        pat_load = 1'b0;
        overlap  = 1'b0;
        moore    = 1'b0;
        cnt_clr  = 1'b0;
        @(posedge clk);
        #1;

        // Non-overlap Mealy, default 1011
        do_reset("t1");
        bit_in(1'b1, 1'b0, "t1 b1");
        bit_in(1'b0, 1'b0, "t1 b2");
        bit_in(1'b1, 1'b0, "t1 b3");
        bit_in(1'b1, 1'b1, "t1 b4");
        bit_in(1'b0, 1'b0, "t1 b5");
        bit_in(1'b1, 1'b0, "t1 b6");
        bit_in(1'b1, 1'b0, "t1 b7");
        check("t1 cnt", int'(cnt_a), 1);

        // Overlap Mealy
        overlap = 1'b1;
        do_reset("t2");
        bit_in(1'b1, 1'b0, "t2 b1");
        bit_in(1'b0, 1'b0, "t2 b2");
        bit_in(1'b1, 1'b0, "t2 b3");
        bit_in(1'b1, 1'b1, "t2 b4");
        bit_in(1'b0, 1'b0, "t2 b5");
        bit_in(1'b1, 1'b0, "t2 b6");
        bit_in(1'b1, 1'b1, "t2 b7");
        check("t2 cnt", int'(cnt_a), 2);

        // Overlap Moore: z one cycle after each accepting edge
        moore = 1'b1;
        do_reset("t3");
        bit_in(1'b1, 1'b0, "t3 b1");
        bit_in(1'b0, 1'b0, "t3 b2");
        bit_in(1'b1, 1'b0, "t3 b3");
        bit_in(1'b1, 1'b0, "t3 b4");
        check("t3 cnt@b4", int'(cnt_a), 1);
        bit_in(1'b0, 1'b1, "t3 b5");
        bit_in(1'b1, 1'b0, "t3 b6");
        bit_in(1'b1, 1'b0, "t3 b7");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, "t3 idle1");
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "t3 idle2");
        check("t3 cnt", int'(cnt_a), 2);
        moore = 1'b0;

        // Pattern 1111, overlap
        do_reset("t4");
        load(4'b1111, "t4 load");
        for (int i = 1; i <= 7; i++) bit_in(1'b1, (i >= 4), $sformatf("t4 b%0d", i));
        check("t4 cnt", int'(cnt_a), 4);

        // Pattern 1111, non-overlap
        overlap = 1'b0;
        do_reset("t5");
        load(4'b1111, "t5 load");
        for (int i = 1; i <= 7; i++) bit_in(1'b1, (i == 4), $sformatf("t5 b%0d", i));
        check("t5 cnt", int'(cnt_a), 1);

        // Gaps in in_valid between bits 2 and 3
        do_reset("t6");
        bit_in(1'b1, 1'b0, "t6 b1");
        bit_in(1'b0, 1'b0, "t6 b2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "t6 gap1");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "t6 gap2");
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "t6 gap3");
        bit_in(1'b1, 1'b0, "t6 b3");
        bit_in(1'b1, 1'b1, "t6 b4");
        check("t6 cnt", int'(cnt_a), 1);

        // pat_load together with bit 4 drops the bit and clears history
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "t7 b1");
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "t7 b2");
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "t7 b3");
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b1011, 1'b0, "t7 b4+load");
        check("t7 cnt", int'(cnt_a), 1);
        bit_in(1'b0, 1'b0, "t7 post0");
        bit_in(1'b1, 1'b0, "t7 post1");
        bit_in(1'b1, 1'b0, "t7 post2");
        check("t7 cnt2", int'(cnt_a), 1);

        // Saturation on the 2-bit counter, then clear during a match
        overlap = 1'b1;
        do_reset("t8");
        check("t8 rst cntb", int'(cnt_b), 0);
        load(4'b1111, "t8 load");
        for (int i = 1; i <= 10; i++) bit_in(1'b1, (i >= 4), $sformatf("t8 b%0d", i));
        check("t8 sat cntb", int'(cnt_b), 3);
        check("t8 cnta", int'(cnt_a), 7);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, "t8 clr");
        check("t8 clr cnta", int'(cnt_a), 0);
        check("t8 clr cntb", int'(cnt_b), 0);

        // Asynchronous reset mid-sequence
        do_reset("t9");
        bit_in(1'b1, 1'b0, "t9 b1");
        bit_in(1'b0, 1'b0, "t9 b2");
        bit_in(1'b1, 1'b0, "t9 b3");
        bit_in(1'b1, 1'b1, "t9 b4");
        bit_in(1'b1, 1'b0, "t9 c1");
        bit_in(1'b0, 1'b0, "t9 c2");
        bit_in(1'b1, 1'b0, "t9 c3");
        check("t9 cnt pre", int'(cnt_a), 1);
        x        = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("t9 z pre", int'(z_a), 1);
        #1;
        reset = 1'b1;
        #1;
        check("t9 async z",   int'(z_a),   0);
        check("t9 async cnt", int'(cnt_a), 0);
        #1;
        reset = 1'b0;
        #1;
        check("t9 rel z", int'(z_a), 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t9 rel cnt", int'(cnt_a), 0);
        bit_in(1'b1, 1'b0, "t9 d1");
        bit_in(1'b0, 1'b0, "t9 d2");
        bit_in(1'b1, 1'b0, "t9 d3");
        bit_in(1'b1, 1'b1, "t9 d4");
        check("t9 cnt end", int'(cnt_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial bit-pattern detector, the next generation of the team's fixed 1011 Mealy detector. It compares a 1-bit serial stream against an N-bit pattern that is loadable at run time. Overlapping or non-overlapping detection and Mealy or Moore output timing are both selectable at run time. A saturating hit counter is included. The block sits in the FSMs library and is fed by a bit-serial source qualified by a valid strobe.

## Interface
- N, 4, pattern length in bits; legal range 2..32
- DEFAULT_PAT, 4'b1011 (N bits), pattern loaded at reset
- CNT_W, 8, hit counter width; legal range 1..32
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- x  in  1  serial data bit; only meaningful when in_valid=1
- in_valid  in  1  x is accepted on this rising edge
- pattern  in  N  new pattern; first-received bit is MSB
- pat_load  in  1  capture pattern this edge
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- moore  in  1  1 = registered (Moore) z, 0 = combinational (Mealy) z
- cnt_clr  in  1  synchronous clear of hit_count
- z  out  1  detection flag
- hit_count  out  CNT_W  saturating number of detections

## Operation
- Internal state:
  - pat_r[N-1:0], the active pattern.
  - hist[N-1:0], the most recent bits, newest in the LSB.
  - fill[0..N], saturating count of valid bits in hist.
  - z_q, the registered hit.
  - hit_count.
- Window: w = {hist[N-2:0], x}.
- Match: m = in_valid & ~pat_load & (fill >= N-1) & (w == pat_r).
- Accepted bit (in_valid=1, pat_load=0):
  - hist <= w.
  - If m & ~overlap: fill <= 0, so the next match needs N fresh bits.
  - Otherwise: fill <= min(fill+1, N).
- No-op cycles: in_valid=0 leaves hist and fill unchanged; only z_q updates.
- Pattern load (pat_load=1):
  - pat_r <= pattern; hist <= 0; fill <= 0; z_q <= 0.
  - pat_load has priority: a bit presented with in_valid in the same cycle is dropped and cannot match.
- Output z:
  - moore=0: z = m, combinational from x, in_valid, pat_load and state.
  - moore=1: z = z_q, where z_q <= m on every edge.
- The mode inputs overlap and moore may change at any time. They take effect on the same cycle; no flush occurs.
- Counter:
  - On m: hit_count <= hit_count+1, saturating at 2^CNT_W-1.
  - cnt_clr has priority over m in the same cycle, so the result is 0 and that hit is not counted.
  - z still reports the hit while cnt_clr is asserted.

## Timing
- Reset values (asynchronous, mid-operation included):
  - pat_r=DEFAULT_PAT, hist=0, fill=0, z_q=0, hit_count=0.
  - z=0 in both modes.
  - Detection restarts from empty after reset releases.
- Mealy latency: z goes high during the cycle in which the last pattern bit is presented with in_valid, i.e. before the capturing edge. Width is one cycle per match.
- Moore latency: z goes high for exactly one cycle, starting at the edge that accepts the last bit.
- hit_count updates at the same edge that accepts the last bit, in both modes.
- Throughput:
  - One bit per cycle.
  - Back-to-back matches in overlap mode can assert z on consecutive cycles.
  - In non-overlap mode, matches are at least N accepted bits apart.
- A load takes effect on the next edge: the first bit after a load is the first bit of a new window.

## Test plan
- Non-overlap Mealy, N=4, default pattern 1011:
  - Stimulus: reset, then one bit per cycle 1,0,1,1,0,1,1.
  - Required: z high only while bit 4 is presented; hit_count=1 at the end.
- Overlap Mealy, same stimulus:
  - Required: z high while bits 4 and 7 are presented; hit_count=2.
  - Moore variant: z high the cycle after bits 4 and 7 are accepted.
- Load pattern 1111, overlap=1:
  - Stimulus: seven 1s.
  - Required: z on bits 4, 5, 6 and 7; hit_count=4.
  - With overlap=0: z on bit 4 only; hit_count=1.
- Gaps and priority:
  - 1011 with in_valid deasserted for 3 cycles between bits 2 and 3 → one match, z only on the valid bit 4.
  - pat_load asserted together with bit 4 → no match, hit_count unchanged.
- Saturation and clear, CNT_W=2, overlap=1, pattern 1111:
  - Stimulus: ten 1s.
  - Required: hit_count stops at 3.
  - cnt_clr asserted in a match cycle → hit_count=0 next cycle while z is still high.
- Asynchronous reset:
  - Stimulus: assert reset mid-sequence after 1,0,1, then release and send 1.
  - Required: z and hit_count go to 0 immediately on reset and no match on the 1; a full 1011 afterwards matches.
